// File: rtl/sa_adc_pkg.sv
// Shared SAR ADC definitions: sample width, decimator FSM states and the accumulator sizing helper.
package sa_adc_pkg;

    localparam int ADC_DATA_W = 14;

    typedef logic [0:0] acc_state_t;
    localparam acc_state_t ST_IDLE  = 1'b0;
    localparam acc_state_t ST_ACCUM = 1'b1;

    // Width that holds the sum of 2^log2_n full-scale samples without wrap.
    function automatic int acc_width(input int log2_n, input int data_w = ADC_DATA_W);
        return data_w + log2_n;
    endfunction

endpackage

// File: rtl/sa_adc_decimator.sv
// Window decimator for SAR ADC results: rounded mean plus min/max per 2^LOG2_N samples,
// presented through a valid/ready holding register with a sticky overrun flag.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | disabled; accumulator held cleared, strobes ignored
// ST_ACCUM | summing strobed samples until the window completes
module sa_adc_decimator
    import sa_adc_pkg::*;
#(
    parameter int DATA_W = ADC_DATA_W,
    parameter int LOG2_N = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              enable_i,
    input  logic [DATA_W-1:0] sample_i,
    input  logic              sample_rdy_i,
    output logic [DATA_W-1:0] avg_o,
    output logic [DATA_W-1:0] min_o,
    output logic [DATA_W-1:0] max_o,
    output logic              avg_valid_o,
    input  logic              avg_ready_i,
    output logic              overrun_o,
    input  logic              clear_overrun_i
);

    localparam int ACC_W = acc_width(LOG2_N, DATA_W);
    localparam logic [LOG2_N-1:0] CNT_LAST = '1;
    localparam logic [ACC_W-1:0]  HALF     = ACC_W'(1) << (LOG2_N - 1);

    acc_state_t        state;
    logic [ACC_W-1:0]  acc;
    logic [LOG2_N-1:0] count;
    logic [DATA_W-1:0] run_min;
    logic [DATA_W-1:0] run_max;

    logic              strobe_acc;
    logic              complete;
    logic              load;
    logic              drop;
    logic [ACC_W-1:0]  acc_sum;
    logic [DATA_W-1:0] avg_next;
    logic [DATA_W-1:0] min_next;
    logic [DATA_W-1:0] max_next;

    // A strobe in the cycle enable falls is not counted.
    assign strobe_acc = (state == ST_ACCUM) && enable_i && sample_rdy_i;
    assign complete   = strobe_acc && (count == CNT_LAST);

    // Sum plus half an LSB of the mean still fits ACC_W, so round-half-up cannot wrap.
    assign acc_sum  = acc + ACC_W'(sample_i);
    assign avg_next = DATA_W'((acc_sum + HALF) >> LOG2_N);
    assign min_next = (sample_i < run_min) ? sample_i : run_min;
    assign max_next = (sample_i > run_max) ? sample_i : run_max;

    assign load = complete && (!avg_valid_o || avg_ready_i);
    assign drop = complete && avg_valid_o && !avg_ready_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= ST_IDLE;
            acc     <= '0;
            count   <= '0;
            run_min <= '1;
            run_max <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable_i) begin
                        state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (!enable_i || complete) begin
                        state   <= enable_i ? ST_ACCUM : ST_IDLE;
                        acc     <= '0;
                        count   <= '0;
                        run_min <= '1;
                        run_max <= '0;
                    end else if (strobe_acc) begin
                        acc     <= acc_sum;
                        count   <= count + 1'b1;
                        run_min <= min_next;
                        run_max <= max_next;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Holding register: data is only rewritten on a load, so it is stable while stalled.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            avg_o       <= '0;
            min_o       <= '0;
            max_o       <= '0;
            avg_valid_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            if (load) begin
                avg_o       <= avg_next;
                min_o       <= min_next;
                max_o       <= max_next;
                avg_valid_o <= 1'b1;
            end else if (avg_valid_o && avg_ready_i) begin
                avg_valid_o <= 1'b0;
            end

            if (drop) begin
                overrun_o <= 1'b1;
            end else if (clear_overrun_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sa_adc_decimator.sv
// Self-checking bench for sa_adc_decimator (N=4): directed scenarios with literal
// expectations plus a randomized run compared each cycle against a window-level model.
module tb_sa_adc_decimator;

    localparam int DATA_W = 14;
    localparam int LOG2_N = 2;
    localparam int N      = 1 << LOG2_N;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              enable_i = 1'b0;
    logic [DATA_W-1:0] sample_i = '0;
    logic              sample_rdy_i = 1'b0;
    logic [DATA_W-1:0] avg_o;
    logic [DATA_W-1:0] min_o;
    logic [DATA_W-1:0] max_o;
    logic              avg_valid_o;
    logic              avg_ready_i = 1'b0;
    logic              overrun_o;
    logic              clear_overrun_i = 1'b0;

    int checks   = 0;
    int failures = 0;

    sa_adc_decimator #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .enable_i        (enable_i),
        .sample_i        (sample_i),
        .sample_rdy_i    (sample_rdy_i),
        .avg_o           (avg_o),
        .min_o           (min_o),
        .max_o           (max_o),
        .avg_valid_o     (avg_valid_o),
        .avg_ready_i     (avg_ready_i),
        .overrun_o       (overrun_o),
        .clear_overrun_i (clear_overrun_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Window-level model: an enabled cycle is one where enable was high on the
    // previous edge and is still high; samples collect in a queue until N arrive.
    int m_q[$];
    bit m_prev_en = 0;
    int m_avg = 0, m_min = 0, m_max = 0;
    bit m_valid = 0, m_ovr = 0;

    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            m_q.delete();
            m_prev_en = 0;
            m_avg = 0; m_min = 0; m_max = 0;
            m_valid = 0; m_ovr = 0;
        end else begin
            bit done;
            bit drop;
            int sum, mn, mx;
            done = 0;
            sum = 0; mn = 0; mx = 0;
            if (!(m_prev_en && enable_i)) begin
                m_q.delete();
            end else if (sample_rdy_i) begin
                m_q.push_back(int'(sample_i));
                if (m_q.size() == N) begin
                    mn = m_q[0];
                    mx = m_q[0];
                    foreach (m_q[i]) begin
                        sum += m_q[i];
                        if (m_q[i] < mn) mn = m_q[i];
                        if (m_q[i] > mx) mx = m_q[i];
                    end
                    done = 1;
                    m_q.delete();
                end
            end
            drop = done && m_valid && !avg_ready_i;
            if (done && !drop) begin
                m_avg   = (sum + N / 2) / N;
                m_min   = mn;
                m_max   = mx;
                m_valid = 1;
            end else if (m_valid && avg_ready_i) begin
                m_valid = 0;
            end
            if (drop) m_ovr = 1;
            else if (clear_overrun_i) m_ovr = 0;
            m_prev_en = enable_i;
        end
    end

    always @(negedge clk_i) begin
        if (!reset_i) begin
            chk("model_valid",   int'(avg_valid_o), int'(m_valid));
            chk("model_overrun", int'(overrun_o),   int'(m_ovr));
            chk("model_avg",     int'(avg_o),       m_avg);
            chk("model_min",     int'(min_o),       m_min);
            chk("model_max",     int'(max_o),       m_max);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic strobe(input int v);
        sample_i     = DATA_W'(v);
        sample_rdy_i = 1'b1;
        tick();
        sample_rdy_i = 1'b0;
    endtask

    task automatic strobes(input int v, input int n);
        for (int i = 0; i < n; i++) strobe(v);
    endtask

    initial begin
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        chk("reset_avg", int'(avg_o), 0);
        chk("reset_min", int'(min_o), 0);
        chk("reset_max", int'(max_o), 0);
        chk("reset_valid", int'(avg_valid_o), 0);
        chk("reset_overrun", int'(overrun_o), 0);

        enable_i    = 1'b1;
        avg_ready_i = 1'b1;
        tick();
        strobe(1); strobe(2); strobe(3); strobe(4);
        chk("w1_valid", int'(avg_valid_o), 1);
        chk("w1_avg", int'(avg_o), 3);
        chk("w1_min", int'(min_o), 1);
        chk("w1_max", int'(max_o), 4);
        tick();
        chk("w1_valid_one_cycle", int'(avg_valid_o), 0);

        strobe(100); strobe(50); strobe(300); strobe(200);
        chk("w2_avg", int'(avg_o), 163);
        chk("w2_min", int'(min_o), 50);
        chk("w2_max", int'(max_o), 300);
        strobes(16383, 4);
        chk("full_scale_avg", int'(avg_o), 16383);
        chk("full_scale_valid", int'(avg_valid_o), 1);
        tick();

        avg_ready_i = 1'b0;
        strobes(8, 8);
        strobes(20, 8);
        chk("stall_avg_held", int'(avg_o), 8);
        chk("stall_overrun", int'(overrun_o), 1);
        avg_ready_i = 1'b1;
        tick();
        avg_ready_i = 1'b0;
        chk("drain_valid", int'(avg_valid_o), 0);
        chk("drain_overrun_sticky", int'(overrun_o), 1);
        clear_overrun_i = 1'b1;
        tick();
        clear_overrun_i = 1'b0;
        chk("clear_overrun", int'(overrun_o), 0);
        strobes(7, 4);
        chk("reload_avg", int'(avg_o), 7);
        strobes(9, 3);
        clear_overrun_i = 1'b1;
        strobe(9);
        clear_overrun_i = 1'b0;
        chk("set_beats_clear", int'(overrun_o), 1);
        chk("drop_keeps_avg", int'(avg_o), 7);
        clear_overrun_i = 1'b1;
        tick();
        clear_overrun_i = 1'b0;

        strobes(12, 3);
        avg_ready_i = 1'b1;
        strobe(12);
        chk("xfer_load_valid", int'(avg_valid_o), 1);
        chk("xfer_load_avg", int'(avg_o), 12);
        chk("xfer_load_overrun", int'(overrun_o), 0);
        tick();
        chk("xfer_drained", int'(avg_valid_o), 0);

        strobe(1000); strobe(1000);
        enable_i = 1'b0;
        tick(); tick(); tick();
        enable_i = 1'b1;
        tick();
        strobes(8, 4);
        chk("discard_avg", int'(avg_o), 8);
        chk("discard_max", int'(max_o), 8);

        avg_ready_i = 1'b0;
        strobes(3, 4);
        chk("pre_reset_valid", int'(avg_valid_o), 1);
        strobe(50); strobe(50);
        #1 reset_i = 1'b1;
        #1;
        chk("async_reset_avg", int'(avg_o), 0);
        chk("async_reset_valid", int'(avg_valid_o), 0);
        chk("async_reset_min", int'(min_o), 0);
        reset_i = 1'b0;
        tick();
        tick();
        strobes(5, 4);
        chk("post_reset_avg", int'(avg_o), 5);
        chk("post_reset_valid", int'(avg_valid_o), 1);

        for (int c = 0; c < 4000; c++) begin
            enable_i        = ($urandom_range(0, 39) != 0);
            sample_rdy_i    = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       sample_i = '0;
                1:       sample_i = '1;
                default: sample_i = DATA_W'($urandom);
            endcase
            avg_ready_i     = (c % 400 < 150) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            clear_overrun_i = ($urandom_range(0, 15) == 0);
            tick();
        end
        sample_rdy_i    = 1'b0;
        clear_overrun_i = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
